// File: rtl/lfsr_word_deserializer.sv
// lfsr_word_deserializer
//   Samples an MSB-first serial stream (Serial_In qualified by Serial_Valid),
//   assembles WORD_W-bit words, and buffers them in a FIFO_DEPTH-entry FIFO.
//   The FIFO head is offered downstream over Word_Valid/Word_Ready.
//   Frame_Err pulses for one cycle when a frame is aborted mid-word.
//   Overflow is sticky once a completed word is dropped because the FIFO is full.
//   Optional build macro LFSR_CHECK_EN: compares every completed word against the
//   generator's 4-bit LFSR recurrence, counting mismatches in Err_Cnt. The
//   reference self-resynchronises from the received word. Without the macro,
//   Err_Cnt is tied to 0 and Seed is ignored.
module lfsr_word_deserializer #(
    parameter int WORD_W     = 4,
    parameter int FIFO_DEPTH = 2,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [3:0]           Seed,
    input  logic                 Serial_In,
    input  logic                 Serial_Valid,
    output logic [WORD_W-1:0]    Word_Out,
    output logic                 Word_Valid,
    input  logic                 Word_Ready,
    output logic                 Frame_Err,
    output logic                 Overflow,
    output logic [ERR_CNT_W-1:0] Err_Cnt
);

    localparam int CNT_W = $clog2(WORD_W);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   bit_cnt, bit_cnt_nxt;
    // Only the first WORD_W-1 bits are held; the final bit completes the word directly.
    logic [WORD_W-2:0]  sr, sr_nxt;
    logic [WORD_W-1:0]  word_done;
    logic               word_push;
    logic               frame_abort;

    logic [WORD_W-1:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [OCC_W-1:0]   occ;
    logic               fifo_full;
    logic               fifo_pop;
    logic               fifo_wr;

    // Frame FSM next-state: shift in valid bits, push on the last bit, abort on a gap.
    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        sr_nxt      = sr;
        word_push   = 1'b0;
        frame_abort = 1'b0;
        word_done   = {sr, Serial_In};
        if (Serial_Valid) begin
            sr_nxt = word_done[WORD_W-2:0];
            if (bit_cnt == CNT_W'(WORD_W - 1)) begin
                word_push   = 1'b1;
                bit_cnt_nxt = '0;
                state_nxt   = IDLE;
            end else begin
                bit_cnt_nxt = bit_cnt + CNT_W'(1);
                state_nxt   = SHIFT;
            end
        end else if (state == SHIFT) begin
            frame_abort = 1'b1;
            bit_cnt_nxt = '0;
            state_nxt   = IDLE;
        end
    end

    // Frame FSM state, bit counter, shift register and the one-cycle abort flag.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            sr        <= '0;
            Frame_Err <= 1'b0;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= bit_cnt_nxt;
            sr        <= sr_nxt;
            Frame_Err <= frame_abort;
        end
    end

    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign fifo_full  = (occ == OCC_W'(FIFO_DEPTH));
    assign fifo_pop   = Word_Valid && Word_Ready;
    assign fifo_wr    = word_push && (!fifo_full || fifo_pop);
    assign Word_Valid = (occ != '0);
    assign Word_Out   = Word_Valid ? mem[rd_ptr] : '0;

    // FIFO pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            Overflow <= 1'b0;
        end else begin
            if (fifo_wr)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (fifo_pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({fifo_wr, fifo_pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
            if (word_push && !fifo_wr)
                Overflow <= 1'b1;
        end
    end

    // FIFO storage; contents are only visible through a nonzero occupancy.
    always_ff @(posedge CLK) begin
        if (fifo_wr)
            mem[wr_ptr] <= word_done;
    end

`ifdef LFSR_CHECK_EN
    logic [3:0] ref_w;

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] c);
        return (c == '1) ? c : c + ERR_CNT_W'(1);
    endfunction

    function automatic logic [3:0] lfsr_next(input logic [3:0] w);
        return {w[2] ^ w[1] ^ w[0], w[3:1]};
    endfunction

    // Compare each completed word (kept or dropped) to the reference, then follow the word.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ref_w   <= Seed;
            Err_Cnt <= '0;
        end else if (word_push) begin
            if (word_done[3:0] != ref_w)
                Err_Cnt <= sat_inc(Err_Cnt);
            ref_w <= lfsr_next(word_done[3:0]);
        end
    end
`else
    logic unused_seed;
    assign unused_seed = ^Seed;
    assign Err_Cnt     = '0;
`endif

endmodule

// File: tb/tb_lfsr_word_deserializer.sv
// Bench for lfsr_word_deserializer: queue-based reference model plus directed frames.
module tb_lfsr_word_deserializer;

    localparam int WORD_W     = 4;
    localparam int FIFO_DEPTH = 2;
    localparam int ERR_CNT_W  = 8;

    logic                 CLK = 1'b0;
    logic                 RST = 1'b0;
    logic [3:0]           Seed = 4'h8;
    logic                 Serial_In = 1'b0;
    logic                 Serial_Valid = 1'b0;
    logic [WORD_W-1:0]    Word_Out;
    logic                 Word_Valid;
    logic                 Word_Ready = 1'b0;
    logic                 Frame_Err;
    logic                 Overflow;
    logic [ERR_CNT_W-1:0] Err_Cnt;

    int checks = 0;
    int errors = 0;

    lfsr_word_deserializer #(
        .WORD_W(WORD_W), .FIFO_DEPTH(FIFO_DEPTH), .ERR_CNT_W(ERR_CNT_W)
    ) dut (
        .CLK(CLK), .RST(RST), .Seed(Seed), .Serial_In(Serial_In),
        .Serial_Valid(Serial_Valid), .Word_Out(Word_Out), .Word_Valid(Word_Valid),
        .Word_Ready(Word_Ready), .Frame_Err(Frame_Err), .Overflow(Overflow),
        .Err_Cnt(Err_Cnt)
    );

    initial forever #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit         bitq[$];
    logic [3:0] fq[$];
    bit         m_ovf  = 0;
    bit         m_ferr = 0;
    int         m_err  = 0;
    logic [3:0] m_ref  = 4'h0;
    logic [3:0] m_w;

    function automatic logic [3:0] lfsr_next(input logic [3:0] w);
        return {w[2] ^ w[1] ^ w[0], w[3:1]};
    endfunction

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            bitq.delete();
            fq.delete();
            m_ovf  = 0;
            m_ferr = 0;
            m_err  = 0;
            m_ref  = Seed;
        end else begin
            m_ferr = 0;
            if (fq.size() > 0 && Word_Ready)
                void'(fq.pop_front());
            if (Serial_Valid) begin
                bitq.push_back(Serial_In);
                if (bitq.size() == WORD_W) begin
                    m_w = 4'h0;
                    foreach (bitq[i]) m_w = {m_w[2:0], bitq[i]};
                    if (fq.size() < FIFO_DEPTH) fq.push_back(m_w);
                    else m_ovf = 1;
`ifdef LFSR_CHECK_EN
                    if (m_w != m_ref && m_err < 255) m_err++;
                    m_ref = lfsr_next(m_w);
`endif
                    bitq.delete();
                end
            end else if (bitq.size() > 0) begin
                bitq.delete();
                m_ferr = 1;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge CLK) begin
        check("word_valid", Word_Valid, fq.size() > 0);
        check("word_out", Word_Out, (fq.size() > 0) ? fq[0] : 4'h0);
        check("frame_err", Frame_Err, m_ferr);
        check("overflow", Overflow, m_ovf);
        check("err_cnt", Err_Cnt, m_err);
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic v, input logic b, input logic r);
        Serial_Valid = v;
        Serial_In    = b;
        Word_Ready   = r;
        @(posedge CLK);
        #1;
    endtask

    task automatic frame(input logic [3:0] w, input logic r_body, input logic r_last);
        for (int i = 3; i >= 1; i--) drive(1'b1, w[i], r_body);
        drive(1'b1, w[0], r_last);
    endtask

    task automatic pulse_reset();
        Serial_Valid = 1'b0;
        RST = 1'b0;
        #1;
        drive(1'b0, 1'b0, 1'b0);
        RST = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        @(posedge CLK);
        #1;
        check("reset_word_valid", Word_Valid, 0);
        check("reset_word_out", Word_Out, 0);
        check("reset_frame_err", Frame_Err, 0);
        check("reset_overflow", Overflow, 0);
        check("reset_err_cnt", Err_Cnt, 0);
        RST = 1'b1;
        drive(1'b0, 1'b0, 1'b1);

        // T1: single word with ready held high
        frame(4'hB, 1'b1, 1'b1);
        check("t1_valid", Word_Valid, 1);
        check("t1_word", Word_Out, 4'hB);
        drive(1'b0, 1'b0, 1'b1);
        check("t1_valid_one_cycle", Word_Valid, 0);

        // T2: three frames into a 2-deep FIFO with ready low
        frame(4'hA, 1'b0, 1'b0);
        frame(4'h5, 1'b0, 1'b0);
        frame(4'hC, 1'b0, 1'b0);
        check("t2_overflow", Overflow, 1);
        check("t2_head_a", Word_Out, 4'hA);
        drive(1'b0, 1'b0, 1'b1);
        check("t2_head_5", Word_Out, 4'h5);
        drive(1'b0, 1'b0, 1'b1);
        check("t2_empty", Word_Valid, 0);
        check("t2_overflow_sticky", Overflow, 1);

        pulse_reset();
        check("rst_clears_overflow", Overflow, 0);

        // T3: aborted frame then a good one
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b1);
        check("t3_frame_err", Frame_Err, 1);
        check("t3_no_word", Word_Valid, 0);
        drive(1'b0, 1'b0, 1'b1);
        check("t3_frame_err_pulse", Frame_Err, 0);
        frame(4'h6, 1'b1, 1'b1);
        check("t3_word", Word_Out, 4'h6);
        drive(1'b0, 1'b0, 1'b1);

        // T4: full FIFO, pop on the same edge as the third push
        frame(4'h1, 1'b0, 1'b0);
        frame(4'h2, 1'b0, 1'b0);
        frame(4'h3, 1'b0, 1'b1);
        check("t4_no_overflow", Overflow, 0);
        check("t4_head_2", Word_Out, 4'h2);
        drive(1'b0, 1'b0, 1'b1);
        check("t4_head_3", Word_Out, 4'h3);
        drive(1'b0, 1'b0, 1'b1);
        check("t4_empty", Word_Valid, 0);

`ifdef LFSR_CHECK_EN
        // T5: sequence checking from Seed 8
        Seed = 4'h8;
        pulse_reset();
        frame(4'h8, 1'b1, 1'b1);
        frame(4'h4, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b1);
        check("t5_match", Err_Cnt, 0);
        frame(4'h3, 1'b1, 1'b1);
        check("t5_mismatch", Err_Cnt, 1);
        frame(4'h1, 1'b1, 1'b1);
        check("t5_resync", Err_Cnt, 1);
        drive(1'b0, 1'b0, 1'b1);
`endif

        // T6: reset mid-frame with one word buffered
        frame(4'h7, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        Serial_Valid = 1'b0;
        RST = 1'b0;
        #1;
        check("t6_word_valid", Word_Valid, 0);
        check("t6_word_out", Word_Out, 0);
        check("t6_frame_err", Frame_Err, 0);
        check("t6_overflow", Overflow, 0);
        check("t6_err_cnt", Err_Cnt, 0);
        drive(1'b0, 1'b0, 1'b1);
        RST = 1'b1;
        drive(1'b0, 1'b0, 1'b1);
        check("t6_no_frame_err", Frame_Err, 0);
        frame(4'hF, 1'b1, 1'b1);
        check("t6_word", Word_Out, 4'hF);
        check("t6_no_frame_err_after", Frame_Err, 0);
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
